// File: rtl/mem_stage.sv
// mem_stage: load/store unit of the Buceros pipeline; drives a req/ack data bus and
// produces the registered MEM-stage register-write result.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              wmem_en_i,
    input  logic              rmem_en_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       store_data_i,
    input  logic              wreg_en_i,
    input  logic [4:0]        wreg_addr_i,
    output logic              stall_o,
    output logic              dbus_req_o,
    output logic              dbus_we_o,
    output logic [ADDR_W-1:0] dbus_addr_o,
    output logic [3:0]        dbus_wstrb_o,
    output logic [DATA_W-1:0] dbus_wdata_o,
    input  logic              dbus_ack_i,
    input  logic [DATA_W-1:0] dbus_rdata_i,
    output logic              mem_wreg_en_o,
    output logic [4:0]        mem_wreg_addr_o,
    output logic [31:0]       mem_wreg_data_o,
    output logic              misaligned_o
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state_q, state_d;
    logic req_q, req_d, we_q, we_d, ld_q, ld_d, b_q, b_d, h_q, h_d, uns_q, uns_d;
    logic wen_q, wen_d, en_q, en_d, mis_q, mis_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [3:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0] off_q, off_d;
    logic [4:0] rd_q, rd_d, waddr_q, waddr_d;
    logic [31:0] data_q, data_d, sh, ld_val;
    logic is_mem, is_b, is_h, misal, start;

    assign is_mem = valid_i & (rmem_en_i | wmem_en_i);
    assign is_b   = funct3_i == 3'b000 || funct3_i == 3'b100;
    assign is_h   = funct3_i == 3'b001 || funct3_i == 3'b101;
    assign misal  = is_h ? addr_i[0] : ~is_b & |addr_i[1:0];
    assign start  = state_q == IDLE && is_mem && !misal;
    assign stall_o = state_q == IDLE ? start : ~dbus_ack_i;
    // Lane of interest is shifted down to bit 0 before extension.
    assign sh     = dbus_rdata_i >> {off_q, 3'b000};
    assign ld_val = b_q ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
                    h_q ? {{16{~uns_q & sh[15]}}, sh[15:0]} : dbus_rdata_i;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        baddr_d = baddr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        b_d     = b_q;
        h_d     = h_q;
        uns_d   = uns_q;
        off_d   = off_q;
        rd_d    = rd_q;
        wen_d   = wen_q;
        en_d    = 1'b0;
        waddr_d = '0;
        data_d  = '0;
        mis_d   = 1'b0;
        if (state_q == IDLE) begin
            if (is_mem && misal) begin
                mis_d = 1'b1;
            end else if (start) begin
                state_d = WAIT;
                req_d   = 1'b1;
                we_d    = wmem_en_i;
                baddr_d = {addr_i[ADDR_W-1:2], 2'b00};
                wstrb_d = !wmem_en_i ? 4'b0000 : is_b ? 4'b0001 << addr_i[1:0] :
                          is_h ? 4'b0011 << addr_i[1:0] : 4'b1111;
                wdata_d = is_b ? {4{store_data_i[7:0]}} :
                          is_h ? {2{store_data_i[15:0]}} : store_data_i;
                ld_d    = rmem_en_i;
                b_d     = is_b;
                h_d     = is_h;
                uns_d   = funct3_i[2];
                off_d   = addr_i[1:0];
                rd_d    = wreg_addr_i;
                wen_d   = wreg_en_i;
            end else if (valid_i) begin
                en_d    = wreg_en_i & |wreg_addr_i;
                waddr_d = wreg_addr_i;
                data_d  = addr_i;
            end
        end else if (dbus_ack_i) begin
            state_d = IDLE;
            req_d   = 1'b0;
            en_d    = ld_q & wen_q & |rd_q;
            waddr_d = rd_q;
            data_d  = ld_q ? ld_val : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            baddr_q <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            ld_q    <= 1'b0;
            b_q     <= 1'b0;
            h_q     <= 1'b0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            en_q    <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            baddr_q <= baddr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            b_q     <= b_d;
            h_q     <= h_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
            en_q    <= en_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
        end
    end

    assign dbus_req_o      = req_q;
    assign dbus_we_o       = we_q;
    assign dbus_addr_o     = baddr_q;
    assign dbus_wstrb_o    = wstrb_q;
    assign dbus_wdata_o    = wdata_q;
    assign mem_wreg_en_o   = en_q;
    assign mem_wreg_addr_o = waddr_q;
    assign mem_wreg_data_o = data_q;
    assign misaligned_o    = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: random and directed stimulus for mem_stage, checked every cycle against a
// transaction-level model of the stage plus literal expectations for the listed scenarios.
module tb_mem_stage;
    logic clk = 1'b0, rst = 1'b1;
    logic valid_i = 0, wmem_en_i = 0, rmem_en_i = 0, wreg_en_i = 0, dbus_ack_i = 0;
    logic [2:0] funct3_i = '0;
    logic [31:0] addr_i = '0, store_data_i = '0, dbus_rdata_i = '0;
    logic [4:0] wreg_addr_i = '0;
    logic stall_o, dbus_req_o, dbus_we_o, mem_wreg_en_o, misaligned_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o, mem_wreg_data_o;
    logic [3:0] dbus_wstrb_o;
    logic [4:0] mem_wreg_addr_o;

    mem_stage dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .wmem_en_i(wmem_en_i), .rmem_en_i(rmem_en_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
        .wreg_en_i(wreg_en_i), .wreg_addr_i(wreg_addr_i), .stall_o(stall_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wstrb_o(dbus_wstrb_o), .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i),
        .dbus_rdata_i(dbus_rdata_i), .mem_wreg_en_o(mem_wreg_en_o),
        .mem_wreg_addr_o(mem_wreg_addr_o), .mem_wreg_data_o(mem_wreg_data_o),
        .misaligned_o(misaligned_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit chk_en = 0;
    // Model state: one outstanding transaction record plus expected outputs.
    bit m_busy = 0, t_load = 0, t_wen = 0;
    logic [2:0] t_f3;
    logic [31:0] t_addr;
    logic [4:0] t_rd;
    int wait_left = 0, ack_force = -1, stall_cycles = 0;
    bit stray_ack = 0, fix_rd_en = 0, last_stall = 0;
    logic [31:0] fix_rdata = '0;
    bit exp_stall = 0, exp_req = 0, exp_we = 0, exp_en = 0, exp_mis = 0;
    logic [31:0] exp_baddr = '0, exp_wdata = '0, exp_data = '0;
    logic [3:0] exp_strb = '0;
    logic [4:0] exp_waddr = '0;
    bit n_busy, n_req, n_we, n_en, n_mis;
    logic [31:0] n_baddr, n_wdata, n_data;
    logic [3:0] n_strb;
    logic [4:0] n_waddr;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0] cap_strb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f);
        return (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] v = w >> (8 * (a % 4));
        if (size_of(f) == 1) begin
            v &= 32'hFF;
            if (f == 3'd0 && v >= 32'h80) v |= 32'hFFFFFF00;
        end else if (size_of(f) == 2) begin
            v &= 32'hFFFF;
            if (f == 3'd1 && v >= 32'h8000) v |= 32'hFFFF0000;
        end
        return v;
    endfunction

    // One clock of stimulus: called at negedge+1 with the instruction inputs already set.
    task automatic step();
        int sz;
        bit mem, al;
        dbus_ack_i = stray_ack | (m_busy && wait_left == 0);
        dbus_rdata_i = fix_rd_en ? fix_rdata : $urandom();
        mem = valid_i && (rmem_en_i || wmem_en_i);
        sz = size_of(funct3_i);
        al = (addr_i % sz) == 0;
        n_busy = m_busy; n_req = exp_req; n_we = exp_we; n_baddr = exp_baddr;
        n_strb = exp_strb; n_wdata = exp_wdata; n_en = 0; n_mis = 0; n_waddr = 0; n_data = 0;
        if (!m_busy) begin
            exp_stall = mem && al;
            n_mis = mem && !al;
            n_en = valid_i && !mem && wreg_en_i && wreg_addr_i != 0;
            n_waddr = wreg_addr_i;
            n_data = addr_i;
            n_req = mem && al;
            if (n_req) begin
                n_busy = 1; t_load = rmem_en_i; t_wen = wreg_en_i; t_f3 = funct3_i;
                t_addr = addr_i; t_rd = wreg_addr_i;
                wait_left = ack_force >= 0 ? ack_force : $urandom_range(0, 3);
                n_we = wmem_en_i;
                n_baddr = addr_i & ~32'd3;
                n_strb = sz == 4 ? 4'hF : 4'((((1 << sz) - 1) << (addr_i % 4)));
                n_wdata = sz == 1 ? (store_data_i & 32'hFF) * 32'h01010101 :
                          sz == 2 ? (store_data_i & 32'hFFFF) * 32'h00010001 : store_data_i;
            end
        end else begin
            exp_stall = !dbus_ack_i;
            if (dbus_ack_i) begin
                n_busy = 0; n_req = 0;
                n_en = t_load && t_wen && t_rd != 0;
                n_waddr = t_rd;
                n_data = load_val(t_f3, t_addr, dbus_rdata_i);
            end else wait_left--;
        end
        last_stall = exp_stall;
        if (exp_stall) stall_cycles++;
        @(posedge clk); #1;
        m_busy = n_busy; exp_req = n_req; exp_we = n_we; exp_baddr = n_baddr; exp_strb = n_strb;
        exp_wdata = n_wdata; exp_en = n_en; exp_mis = n_mis; exp_waddr = n_waddr; exp_data = n_data;
        if (dbus_req_o) begin cap_addr = dbus_addr_o; cap_strb = dbus_wstrb_o; cap_wdata = dbus_wdata_o; end
        @(negedge clk); #1;
    endtask

    task automatic do_instr(input bit r, input bit w, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] d, input bit we, input logic [4:0] rd);
        int n = 0;
        valid_i = 1; rmem_en_i = r; wmem_en_i = w; funct3_i = f; addr_i = a;
        store_data_i = d; wreg_en_i = we; wreg_addr_i = rd;
        stall_cycles = 0;
        step();
        while (last_stall && n < 40) begin n++; step(); end
        if (n >= 40) chk("stall_timeout", 32'(n), 32'd0);
        valid_i = 0;
    endtask

    task automatic idle();
        valid_i = 0;
        step();
    endtask

    always @(negedge clk) begin
        #3;
        if (chk_en) begin
            chk("stall_o", stall_o, exp_stall);
            chk("dbus_req_o", dbus_req_o, exp_req);
            chk("misaligned_o", misaligned_o, exp_mis);
            chk("mem_wreg_en_o", mem_wreg_en_o, exp_en);
            if (exp_en) begin
                chk("mem_wreg_addr_o", mem_wreg_addr_o, exp_waddr);
                chk("mem_wreg_data_o", mem_wreg_data_o, exp_data);
            end
            if (exp_req) begin
                chk("dbus_we_o", dbus_we_o, exp_we);
                chk("dbus_addr_o", dbus_addr_o, exp_baddr);
                if (exp_we) begin
                    chk("dbus_wstrb_o", dbus_wstrb_o, exp_strb);
                    chk("dbus_wdata_o", dbus_wdata_o, exp_wdata);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req", dbus_req_o, 0);
        chk("rst_en", mem_wreg_en_o, 0);
        chk("rst_data", mem_wreg_data_o, 0);
        chk("rst_mis", misaligned_o, 0);
        rst = 0;
        chk_en = 1;
        // LW 0x100, ack one cycle after the request
        ack_force = 1; fix_rd_en = 1; fix_rdata = 32'hDEADBEEF;
        do_instr(1, 0, 3'b010, 32'h100, 0, 1, 5'd7);
        chk("lw_stalls", 32'(stall_cycles), 32'd2);
        chk("lw_data", mem_wreg_data_o, 32'hDEADBEEF);
        chk("lw_en", mem_wreg_en_o, 1);
        // LB / LBU at 0x103
        ack_force = 0; fix_rdata = 32'h80FFFF7F;
        do_instr(1, 0, 3'b000, 32'h103, 0, 1, 5'd8);
        chk("lb_data", mem_wreg_data_o, 32'hFFFFFF80);
        do_instr(1, 0, 3'b100, 32'h103, 0, 1, 5'd8);
        chk("lbu_data", mem_wreg_data_o, 32'h00000080);
        fix_rd_en = 0;
        // SH 0x202
        do_instr(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 1, 5'd3);
        chk("sh_addr", cap_addr, 32'h200);
        chk("sh_strb", 32'(cap_strb), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCDABCD);
        chk("sh_en", mem_wreg_en_o, 0);
        // misaligned LW
        do_instr(1, 0, 3'b010, 32'h101, 0, 1, 5'd4);
        chk("mis_stalls", 32'(stall_cycles), 32'd0);
        chk("mis_pulse", misaligned_o, 1);
        chk("mis_req", dbus_req_o, 0);
        idle();
        chk("mis_clear", misaligned_o, 0);
        // back-to-back ALU ops
        ack_force = -1;
        do_instr(0, 0, 3'b000, 32'hCAFE0001, 0, 1, 5'd5);
        chk("alu_x5_en", mem_wreg_en_o, 1);
        chk("alu_x5_data", mem_wreg_data_o, 32'hCAFE0001);
        do_instr(0, 0, 3'b000, 32'h00000022, 0, 1, 5'd0);
        chk("alu_x0_en", mem_wreg_en_o, 0);
        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int k = $urandom_range(0, 3);
            logic [31:0] a = $urandom_range(0, 1) ? ($urandom() & ~32'd3) : $urandom();
            logic [2:0] f = k == 2 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            if (k == 3) idle();
            else do_instr(k == 1, k == 2, f, a, $urandom(), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31)));
        end
        // long ack delay, then reset in the middle of the wait
        ack_force = 100;
        valid_i = 1; rmem_en_i = 1; wmem_en_i = 0; funct3_i = 3'b010; addr_i = 32'h340;
        wreg_en_i = 1; wreg_addr_i = 5'd9;
        stall_cycles = 0;
        repeat (6) step();
        chk("long_stalls", 32'(stall_cycles), 32'd6);
        chk("long_stall_now", stall_o, 1);
        chk("long_req", dbus_req_o, 1);
        chk_en = 0;
        valid_i = 0;
        rst = 1;
        #1;
        chk("arst_req", dbus_req_o, 0);
        chk("arst_en", mem_wreg_en_o, 0);
        chk("arst_addr", dbus_addr_o, 0);
        chk("arst_wstrb", 32'(dbus_wstrb_o), 0);
        chk("arst_stall", stall_o, 0);
        #2 rst = 0;
        m_busy = 0; exp_req = 0; exp_we = 0; exp_en = 0; exp_mis = 0; exp_stall = 0;
        exp_baddr = 0; exp_strb = 0; exp_wdata = 0;
        @(negedge clk); #1;
        chk_en = 1;
        ack_force = -1;
        stray_ack = 1;
        step();
        stray_ack = 0;
        chk("late_ack_req", dbus_req_o, 0);
        chk("late_ack_en", mem_wreg_en_o, 0);
        do_instr(1, 0, 3'b101, 32'h3FE, 0, 1, 5'd12);
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
